// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream controller.
//   reader_state_t : reader FSM states (IDLE / RUN / DRAIN)
//   BUF_DEPTH      : number of entries in the output skid buffer
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order buffer that holds words returned by the FIFO until the
// stream consumer accepts them. The head entry drives the stream directly.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push, data  : write one word (the captured FIFO read data)
//   pop         : head word accepted downstream (only asserted when head_valid)
//   occ         : current occupancy, 0..2
//   head_data   : oldest buffered word
//   head_valid  : buffer not empty
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [1:0]       occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            occ_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) entry0 <= data;
                    else               entry1 <= data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: occupancy unchanged, the new
                    // word lands behind whatever remains after the pop.
                    if (occ_q == 2'd1) begin
                        entry0 <= data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ({30'b0, occ_q} <= BUF_DEPTH);
        end
    end

    assign occ        = occ_q;
    assign head_data  = entry0;
    assign head_valid = (occ_q != 2'd0);

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: issues read strobes with a
// credit check, absorbs the FIFO's one-cycle read latency and presents the
// words on a valid/ready stream.
// Optional feature macro: FIFO_READER_STATS_EN adds the drained_count port.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   en             : 1 = fetch from the FIFO, 0 = stop fetching and drain
//   fifo_data      : FIFO read data, valid the cycle after fifo_read
//   fifo_empty     : FIFO empty flag
//   fifo_read      : FIFO read strobe
//   m_data/m_valid : stream output, m_ready stream backpressure
//   busy           : activity in progress (not IDLE, data buffered or in flight)
//   drained_count  : stream transfers, modulo 2^CNT_W (stats build only)
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = 4
`ifdef FIFO_READER_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_read,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_W-1:0] drained_count
`endif
);

    reader_state_t state;
    logic          inflight;
    logic          pop;
    logic [1:0]    occ;
    logic [2:0]    credit;

    assign pop = m_valid && m_ready;

    // Words already committed (buffered + in flight) must stay below the
    // buffer depth once this cycle's pop is accounted for.
    always_comb begin
        credit    = {1'b0, occ} + {2'b0, inflight};
        fifo_read = !rst && (state == RUN) && !fifo_empty &&
                    (credit < (3'(BUF_DEPTH) + {2'b0, pop}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read;
            unique case (state)
                IDLE:  if (en) state <= RUN;
                RUN:   if (!en) state <= DRAIN;
                DRAIN: begin
                    if (!inflight && occ == 2'd0) state <= IDLE;
                    else if (en)                  state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo_reader_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .data      (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data),
        .head_valid(m_valid)
    );

    assign busy = (state != IDLE) || (occ != 2'd0) || inflight;

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)      drained_count <= '0;
        else if (pop) drained_count <= drained_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. The FIFO is emulated with a
// queue and a registered read-data output; a scoreboard queue holds every
// word read from the FIFO and each stream transfer must match its front.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_read;
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
`ifdef FIFO_READER_STATS_EN
    logic [1:0] drained_count;
`endif

    fifo_stream_reader #(
        .WIDTH(4)
`ifdef FIFO_READER_STATS_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_read (fifo_read),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy)
`ifdef FIFO_READER_STATS_EN
        ,
        .drained_count(drained_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_reads = 0;
    int         n_xfer = 0;
    int         cnt_model = 0;
    logic [3:0] fq[$];
    logic [3:0] sb[$];
    logic       s_read, s_valid;
    logic [3:0] s_data;
    logic       stall_prev = 1'b0;
    logic [3:0] hold_d = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: sample mid-cycle, then apply FIFO / model updates
    // just after the rising edge.
    task automatic step();
        logic       r, v, rd, e, rs;
        logic [3:0] d, w;
        @(negedge clk);
        r = fifo_read; v = m_valid; d = m_data; rd = m_ready; e = fifo_empty; rs = rst;
        s_read = r; s_valid = v; s_data = d;
        chk("overread", {31'b0, r & e}, 0);
        if (!rs) begin
            if (stall_prev) begin
                chk("hold_valid", {31'b0, v}, 1);
                chk("hold_data", {28'b0, d}, {28'b0, hold_d});
            end
            if (v && rd) begin
                if (sb.size() == 0) chk("xfer_unexpected", 1, 0);
                else                chk("xfer_data", {28'b0, d}, {28'b0, sb.pop_front()});
                n_xfer++;
            end
            stall_prev = v && !rd;
            hold_d     = d;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rs) begin
            sb.delete();
            cnt_model = 0;
        end else begin
            if (v && rd) cnt_model = (cnt_model + 1) % 4;
            if (r && fq.size() != 0) begin
                w = fq.pop_front();
                fifo_data = w;
                sb.push_back(w);
                n_reads++;
            end
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fq.push_back(4'($urandom_range(0, 15)));
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic drain_idle(input int budget);
        en = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!busy) break;
        end
        chk("drain_idle_busy", {31'b0, busy}, 0);
    endtask

    logic       rd_h[8];
    logic       v_h[8];
    logic [3:0] d_h[8];
    logic [3:0] first_w;
    int         base_r, base_x;

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        step();
        step();
        chk("rst_fifo_read", {31'b0, fifo_read}, 0);
        chk("rst_m_valid", {31'b0, m_valid}, 0);
        chk("rst_m_data", {28'b0, m_data}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_state", dut.state, IDLE);
        rst = 1'b0;
        step();

        // 1: three words, continuous ready -> reads N..N+2, data N+2..N+4
        fq.push_back(4'h3); fq.push_back(4'h5); fq.push_back(4'h9);
        fifo_empty = 1'b0;
        en = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            rd_h[k] = s_read; v_h[k] = s_valid; d_h[k] = s_data;
        end
        chk("t1_read0", {31'b0, rd_h[0]}, 0);
        chk("t1_read1", {31'b0, rd_h[1]}, 1);
        chk("t1_read2", {31'b0, rd_h[2]}, 1);
        chk("t1_read3", {31'b0, rd_h[3]}, 1);
        chk("t1_read4", {31'b0, rd_h[4]}, 0);
        chk("t1_valid2", {31'b0, v_h[2]}, 0);
        chk("t1_valid3", {31'b0, v_h[3]}, 1);
        chk("t1_data3", {28'b0, d_h[3]}, 3);
        chk("t1_data4", {28'b0, d_h[4]}, 5);
        chk("t1_data5", {28'b0, d_h[5]}, 9);
        chk("t1_valid6", {31'b0, v_h[6]}, 0);
        drain_idle(20);

        // 2: backpressure -> exactly two reads, head held; then gapless drain
        load(4);
        first_w = fq[0];
        en = 1'b1; m_ready = 1'b0;
        base_r = n_reads;
        for (int k = 0; k < 8; k++) step();
        chk("t2_reads", n_reads - base_r, 2);
        chk("t2_valid", {31'b0, m_valid}, 1);
        chk("t2_head", {28'b0, m_data}, {28'b0, first_w});
        m_ready = 1'b1;
        base_x = n_xfer;
        for (int k = 0; k < 4; k++) step();
        chk("t2_gapless", n_xfer - base_x, 4);
        drain_idle(20);

        // 3: en drops in the cycle fifo_read is high
        load(3);
        en = 1'b1; m_ready = 1'b1;
        step();
        en = 1'b0;
        step();
        chk("t3_read_when_drop", {31'b0, s_read}, 1);
        base_r = n_reads; base_x = n_xfer;
        for (int k = 0; k < 6; k++) step();
        chk("t3_no_more_reads", n_reads - base_r, 0);
        chk("t3_one_xfer", n_xfer - base_x, 1);
        chk("t3_busy", {31'b0, busy}, 0);
        chk("t3_state", dut.state, IDLE);
        fq.delete();
        fifo_empty = 1'b1;

        // 4: FIFO empty throughout
        en = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_read", {31'b0, s_read}, 0);
            chk("t4_valid", {31'b0, s_valid}, 0);
        end
        chk("t4_state", dut.state, RUN);
        chk("t4_busy", {31'b0, busy}, 1);
        drain_idle(20);

        // 5: reset while the buffer is full
        load(4);
        en = 1'b1; m_ready = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("t5_full_valid", {31'b0, m_valid}, 1);
        chk("t5_full_occ", {30'b0, dut.u_skid.occ}, 2);
        rst = 1'b1;
        step();
        chk("t5_rst_cycle_read", {31'b0, s_read}, 0);
        rst = 1'b0; en = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        step();
        chk("t5_after_valid", {31'b0, s_valid}, 0);
        chk("t5_after_read", {31'b0, s_read}, 0);
        chk("t5_after_busy", {31'b0, busy}, 0);

        // 6: five transfers after reset
        load(5);
        en = 1'b1; m_ready = 1'b1;
        base_x = n_xfer;
        for (int k = 0; k < 30 && (n_xfer - base_x) < 5; k++) step();
        chk("t6_xfers", n_xfer - base_x, 5);
        drain_idle(20);
`ifdef FIFO_READER_STATS_EN
        chk("t6_drained_wrap", {30'b0, drained_count}, 1);
`endif

        // Random traffic against the scoreboard
        for (int k = 0; k < 400; k++) begin
            if (fq.size() < 6 && $urandom_range(0, 2) == 0) load(1);
            en      = ($urandom_range(0, 7) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain_idle(50);
        chk("rand_scoreboard_empty", sb.size(), 0);
`ifdef FIFO_READER_STATS_EN
        chk("rand_drained_count", {30'b0, drained_count}, cnt_model);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
